truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Synthesisable sequential successor to the static two-input structural exercise bench.
- Exhaustively walks all 2^N_IN input combinations of a combinational DUT and waits a programmable settle time per vector.
- Samples the DUT output and compares it against a parameterised expected truth table.
- Reports pass/fail and a mismatch count; used on-board and in sim for any N-input structural module.

Parameters:
- N_IN, 2, number of DUT inputs (1..8).
- SETTLE, 1, clock cycles stim is held before sampling resp (>=1).
- EXPECT, 4'b1000, expected truth table, width 2^N_IN; bit k = expected resp when stim == k (default = AND).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- stim  out  N_IN  vector driven to DUT inputs.
- resp  in  1  DUT output.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high when the last sweep had zero mismatches; held until the next start.
- err_count  out  N_IN+1  mismatch count of the current or last sweep; saturates at 2^N_IN.

Behaviour:
- Reset (async, rst_n low): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - start=1 -> DRIVE next cycle; stim=0, err_count=0, pass=0, busy=1.
  - start=0 -> hold all outputs.
- DRIVE: the settle counter counts SETTLE cycles with stim stable, then goes to SAMPLE.
- SAMPLE (one cycle): compare resp with EXPECT[stim].
  - On mismatch, err_count increments.
  - If stim == 2^N_IN-1 -> FINISH.
  - Otherwise stim increments and the FSM returns to DRIVE with the settle counter cleared.
- FINISH (one cycle): done=1, busy=0, pass=(err_count==0) using the final count including the last sample; then IDLE.
  - stim stays at its last value until the next start.
- Latency: start to done = 1 + 2^N_IN*(SETTLE+1) + 1 cycles.
  - N_IN=2, SETTLE=1 -> 10 cycles.
- start while busy: ignored; no restart, no effect on count.
- start in the same cycle as FINISH: ignored, because the FSM is not yet in IDLE; a new start must arrive in IDLE.
- Stim wrap: stim never wraps inside a sweep. The all-ones vector is the last one sampled.
- Counter width: err_count is N_IN+1 bits, so the full-fail count 2^N_IN is representable. Saturation is defensive only.
- resp X/Z in simulation: it is a mismatch only if the comparison resolves false. A bench must not rely on X behaviour.
- Reset mid-sweep: immediate abort to the reset values; done is not pulsed.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN.
- Defined: adds two ports.
  - first_fail_idx  out  N_IN  stim value of the first mismatch in the sweep.
  - first_fail_vld  out  1  high once a mismatch has been captured.
  - Both clear on start and on reset.
  - Both are captured only on the first mismatch and hold through FINISH until the next start.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package tts_pkg:
  - state enum typedef (IDLE, DRIVE, SAMPLE, FINISH);
  - localparam function for vector count (1<<N_IN);
  - latency helper constant.
- One natural sub-module: tts_settle_cnt, a loadable down-counter emitting a tick after SETTLE cycles, reused per vector.
- FSM, stim counter and compare stay in the top.

Test Plan:
- Correct AND DUT (N_IN=2, SETTLE=1, EXPECT=4'b1000), start pulse -> stim sequence 0,1,2,3; done at cycle 10; pass=1; err_count=0.
- DUT = OR against the AND table -> err_count=2 (indices 1,2), pass=0; with the macro: first_fail_idx=1, first_fail_vld=1.
- DUT output tied to constant 0 with EXPECT=4'b0000 and SETTLE=3 -> 4 vectors each held 3 cycles; done 18 cycles after start; pass=1.
- Inverted DUT (all wrong), N_IN=3, EXPECT=8'hFF vs resp=0 -> err_count=8, no overflow, pass=0.
- start re-pulsed at cycle 4 of a sweep -> ignored; single done; counts unchanged. Then rst_n low at cycle 6 of a new sweep -> all outputs 0 immediately, no done, stim=0.
- start asserted in the FINISH cycle -> no new sweep. start one cycle later in IDLE -> new sweep; err_count cleared to 0 and pass cleared to 0 on entry.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state type,
// vector-count and counter-width helpers, and the sweep latency formula.
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } tts_state_e;

    // Number of input vectors walked by one sweep.
    function automatic int vecCount(input int nIn);
        return 1 << nIn;
    endfunction

    // Width of a down-counter that must hold values 0 .. value-1.
    function automatic int cntWidth(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Cycles from the start pulse cycle to the done pulse cycle, inclusive.
    function automatic int sweepLatency(input int nIn, input int settle);
        return 1 + vecCount(nIn) * (settle + 1) + 1;
    endfunction

    localparam int DEFAULT_LATENCY = sweepLatency(2, 1);

endpackage

// File: rtl/tts_settle_cnt.sv
// Loadable down-counter that times how long a stimulus vector is held.
// It is reloaded on every new vector and raises tick_o in the last hold cycle.
module tts_settle_cnt
    import tts_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            W        = cntWidth(SETTLE);
    localparam logic [W-1:0]  LOAD_VAL = W'(SETTLE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    // Reload on a new vector, otherwise count down while the hold is active.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input combination of an
// external combinational block, holds each vector for SETTLE cycles,
// samples the response and counts mismatches against EXPECT.
// Optional feature macro: TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN adds capture
// of the first failing vector (first_fail_idx_o / first_fail_vld_o).
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = 4'b1000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    output logic [N_IN-1:0] stim_o,
    input  logic            resp_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN:0]   err_count_o
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
    ,
    output logic [N_IN-1:0] first_fail_idx_o,
    output logic            first_fail_vld_o
`endif
);

    localparam int             VEC     = vecCount(N_IN);
    localparam logic [N_IN:0]  ERR_MAX = (N_IN + 1)'(VEC);

    tts_state_e      state_q;
    tts_state_e      state_d;
    logic [N_IN-1:0] stim_q;
    logic [N_IN-1:0] stim_d;
    logic [N_IN:0]   errCount_q;
    logic [N_IN:0]   errCount_d;
    logic            pass_q;
    logic            pass_d;

    logic            settleLoad;
    logic            settleEn;
    logic            settleTick;
    logic            lastVec;
    logic            expBit;
    logic            mismatch;
    logic            sweepStart;

    assign lastVec    = (stim_q == {N_IN{1'b1}});
    assign expBit     = EXPECT[stim_q];
    assign mismatch   = (resp_i != expBit);
    assign sweepStart = (state_q == IDLE) && start_i;

    tts_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (settleLoad),
        .en_i   (settleEn),
        .tick_o (settleTick)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only counts in IDLE, so a pulse while busy or in FINISH is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = DRIVE;
            DRIVE:   if (settleTick) state_d = SAMPLE;
            SAMPLE:  state_d = lastVec ? FINISH : DRIVE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and control decode from the current state.
    always_comb begin
        busy_o     = (state_q == DRIVE) || (state_q == SAMPLE);
        done_o     = (state_q == FINISH);
        settleEn   = (state_q == DRIVE);
        settleLoad = sweepStart || ((state_q == SAMPLE) && !lastVec);
    end

    // Datapath next values: clear on start, compare and advance in SAMPLE.
    // The pass flag is settled on the last sample so it is valid alongside done.
    always_comb begin
        stim_d     = stim_q;
        errCount_d = errCount_q;
        pass_d     = pass_q;
        if (sweepStart) begin
            stim_d     = '0;
            errCount_d = '0;
            pass_d     = 1'b0;
        end else if (state_q == SAMPLE) begin
            if (mismatch && (errCount_q != ERR_MAX)) begin
                errCount_d = errCount_q + (N_IN + 1)'(1);
            end
            if (lastVec) begin
                pass_d = (errCount_d == '0);
            end else begin
                stim_d = stim_q + N_IN'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stim_q     <= '0;
            errCount_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            stim_q     <= stim_d;
            errCount_q <= errCount_d;
            pass_q     <= pass_d;
        end
    end

    assign stim_o      = stim_q;
    assign pass_o      = pass_q;
    assign err_count_o = errCount_q;

`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
    logic [N_IN-1:0] ffIdx_q;
    logic [N_IN-1:0] ffIdx_d;
    logic            ffVld_q;
    logic            ffVld_d;

    // First-failure capture: cleared on start, latched only by the first mismatch.
    always_comb begin
        ffIdx_d = ffIdx_q;
        ffVld_d = ffVld_q;
        if (sweepStart) begin
            ffIdx_d = '0;
            ffVld_d = 1'b0;
        end else if ((state_q == SAMPLE) && mismatch && !ffVld_q) begin
            ffIdx_d = stim_q;
            ffVld_d = 1'b1;
        end
    end

    // First-failure registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ffIdx_q <= '0;
            ffVld_q <= 1'b0;
        end else begin
            ffIdx_q <= ffIdx_d;
            ffVld_q <= ffVld_d;
        end
    end

    assign first_fail_idx_o = ffIdx_q;
    assign first_fail_vld_o = ffVld_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances cover the AND/OR 2-input
// case, a long settle time, and a 3-input all-wrong sweep. Expected stimulus
// order and sweep results are queued when a sweep is launched and checked
// when the DUT produces them.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       startA, startB, startC;
    logic [1:0] stimA, stimB;
    logic [2:0] stimC;
    logic       respA, respB, respC;
    logic       busyA, busyB, busyC;
    logic       doneA, doneB, doneC;
    logic       passA, passB, passC;
    logic [2:0] errA, errB;
    logic [3:0] errC;
    bit         modeOr;

`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
    logic [1:0] ffIdxA, ffIdxB;
    logic [2:0] ffIdxC;
    logic       ffVldA, ffVldB, ffVldC;
`endif

    assign respA = modeOr ? (|stimA) : (&stimA);
    assign respB = 1'b0;
    assign respC = 1'b0;

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1000)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startA), .stim_o(stimA),
        .resp_i(respA), .busy_o(busyA), .done_o(doneA), .pass_o(passA),
        .err_count_o(errA)
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        , .first_fail_idx_o(ffIdxA), .first_fail_vld_o(ffVldA)
`endif
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0000)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startB), .stim_o(stimB),
        .resp_i(respB), .busy_o(busyB), .done_o(doneB), .pass_o(passB),
        .err_count_o(errB)
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        , .first_fail_idx_o(ffIdxB), .first_fail_vld_o(ffVldB)
`endif
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECT(8'hFF)) dutC (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startC), .stim_o(stimC),
        .resp_i(respC), .busy_o(busyC), .done_o(doneC), .pass_o(passC),
        .err_count_o(errC)
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        , .first_fail_idx_o(ffIdxC), .first_fail_vld_o(ffVldC)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] expTableA = 4'b1000;

    typedef struct {
        int err;
        bit pass;
        int cycles;
    } res_t;

    res_t resQ[$];
    int   expStimQ[$];

    // Expected AND/OR mismatch count against the AND table.
    function automatic int modelErrA(input bit orMode);
        int e = 0;
        for (int k = 0; k < 4; k++) begin
            bit r;
            r = orMode ? (k != 0) : (k == 3);
            if (r != expTableA[k]) e++;
        end
        return e;
    endfunction

    // Index of the first mismatching vector, -1 when none.
    function automatic int modelFirstA(input bit orMode);
        for (int k = 0; k < 4; k++) begin
            bit r;
            r = orMode ? (k != 0) : (k == 3);
            if (r != expTableA[k]) return k;
        end
        return -1;
    endfunction

    // Monitor for dutA: each new stimulus vector seen while busy is checked against the queue.
    bit       inSweep = 0;
    logic [1:0] lastStim;
    always @(negedge clk) begin
        if (busyA) begin
            if (!inSweep || (stimA != lastStim)) begin
                total++;
                if (expStimQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL stim_seq: got unexpected stim %0d, want none", stimA);
                end else begin
                    int e;
                    e = expStimQ.pop_front();
                    if (int'(stimA) !== e) begin
                        bad++;
                        $display("[TB] FAIL stim_seq: got %0d want %0d", stimA, e);
                    end
                end
            end
            lastStim = stimA;
            inSweep  = 1;
        end else begin
            inSweep = 0;
        end
    end

    task automatic applyStimulus(input bit orMode, input int sweeps);
        for (int s = 0; s < sweeps; s++) begin
            for (int k = 0; k < 4; k++) expStimQ.push_back(k);
            resQ.push_back('{modelErrA(orMode), modelErrA(orMode) == 0, 1 + 4 * 2 + 1});
        end
    endtask

    task automatic waitDoneA(input int startCyc, output int cycles, output bit ok);
        cycles = startCyc;
        ok     = doneA;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            cycles++;
            if (doneA) ok = 1;
        end
    endtask

    task automatic checkOutputA(input int cycles, input bit ok);
        res_t r;
        r = resQ.pop_front();
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL a_timeout: done not seen, want done by cycle %0d", r.cycles);
        end
        total++;
        if (cycles !== r.cycles) begin
            bad++;
            $display("[TB] FAIL a_latency: got %0d want %0d", cycles, r.cycles);
        end
        total++;
        if (int'(errA) !== r.err) begin
            bad++;
            $display("[TB] FAIL a_err_count: got %0d want %0d", errA, r.err);
        end
        total++;
        if (passA !== r.pass) begin
            bad++;
            $display("[TB] FAIL a_pass: got %0b want %0b", passA, r.pass);
        end
        total++;
        if (busyA !== 1'b0 || stimA !== 2'd3) begin
            bad++;
            $display("[TB] FAIL a_finish_state: got busy=%0b stim=%0d want busy=0 stim=3", busyA, stimA);
        end
    endtask

    task automatic test_reset;
        total++;
        if (stimA !== 2'd0 || busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0 || errA !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_a: got stim=%0d busy=%0b done=%0b pass=%0b err=%0d want all 0",
                     stimA, busyA, doneA, passA, errA);
        end
        total++;
        if (busyB !== 1'b0 || errB !== 3'd0 || busyC !== 1'b0 || errC !== 4'd0 || passC !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_bc: got busyB=%0b errB=%0d busyC=%0b errC=%0d passC=%0b want all 0",
                     busyB, errB, busyC, errC, passC);
        end
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        total++;
        if (ffVldA !== 1'b0 || ffIdxA !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_ff: got vld=%0b idx=%0d want 0 0", ffVldA, ffIdxA);
        end
`endif
    endtask

    task automatic test_and_pass;
        int cyc;
        bit ok;
        modeOr = 0;
        applyStimulus(0, 1);
        @(negedge clk); startA = 1;
        @(negedge clk); startA = 0;
        waitDoneA(2, cyc, ok);
        checkOutputA(cyc, ok);
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        total++;
        if (ffVldA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL and_ff_vld: got %0b want 0", ffVldA);
        end
`endif
        @(negedge clk);
        total++;
        if (doneA !== 1'b0 || passA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL and_after_done: got done=%0b pass=%0b want done=0 pass=1", doneA, passA);
        end
    endtask

    task automatic test_or_fail;
        int cyc;
        bit ok;
        modeOr = 1;
        applyStimulus(1, 1);
        @(negedge clk); startA = 1;
        @(negedge clk); startA = 0;
        total++;
        if (busyA !== 1'b1 || passA !== 1'b0 || errA !== 3'd0) begin
            bad++;
            $display("[TB] FAIL or_entry: got busy=%0b pass=%0b err=%0d want 1 0 0", busyA, passA, errA);
        end
        waitDoneA(2, cyc, ok);
        checkOutputA(cyc, ok);
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        total++;
        if (ffVldA !== 1'b1 || int'(ffIdxA) !== modelFirstA(1)) begin
            bad++;
            $display("[TB] FAIL or_first_fail: got vld=%0b idx=%0d want vld=1 idx=%0d",
                     ffVldA, ffIdxA, modelFirstA(1));
        end
`endif
    endtask

    task automatic test_settle3;
        int  cyc;
        bit  ok;
        int  wantCyc;
        wantCyc = 1 + 4 * (3 + 1) + 1;
        @(negedge clk); startB = 1;
        @(negedge clk); startB = 0;
        cyc = 2;
        ok  = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (doneB) ok = 1;
        end
        total++;
        if (!ok || cyc !== wantCyc) begin
            bad++;
            $display("[TB] FAIL b_latency: got done=%0b cycle=%0d want done at %0d", ok, cyc, wantCyc);
        end
        total++;
        if (passB !== 1'b1 || errB !== 3'd0 || stimB !== 2'd3) begin
            bad++;
            $display("[TB] FAIL b_result: got pass=%0b err=%0d stim=%0d want 1 0 3", passB, errB, stimB);
        end
    endtask

    task automatic test_all_wrong;
        int cyc;
        bit ok;
        int wantErr;
        int wantCyc;
        logic [7:0] tbl;
        tbl     = 8'hFF;
        wantErr = 0;
        for (int k = 0; k < 8; k++) if (tbl[k] != 1'b0) wantErr++;
        wantCyc = 1 + 8 * 2 + 1;
        @(negedge clk); startC = 1;
        @(negedge clk); startC = 0;
        cyc = 2;
        ok  = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (doneC) ok = 1;
        end
        total++;
        if (!ok || cyc !== wantCyc) begin
            bad++;
            $display("[TB] FAIL c_latency: got done=%0b cycle=%0d want done at %0d", ok, cyc, wantCyc);
        end
        total++;
        if (int'(errC) !== wantErr || passC !== 1'b0) begin
            bad++;
            $display("[TB] FAIL c_result: got err=%0d pass=%0b want err=%0d pass=0", errC, passC, wantErr);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit ok;
        int extraDone;
        modeOr = 1;
        applyStimulus(1, 1);
        @(negedge clk); startA = 1;
        cyc = 1;
        ok  = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            startA = (cyc == 4);
            if (doneA) ok = 1;
        end
        startA = 0;
        checkOutputA(cyc, ok);
        extraDone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (doneA) extraDone++;
        end
        total++;
        if (extraDone !== 0) begin
            bad++;
            $display("[TB] FAIL restart_ignored: got %0d extra done pulses want 0", extraDone);
        end

        modeOr = 0;
        applyStimulus(0, 1);
        @(negedge clk); startA = 1;
        @(negedge clk); startA = 0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if (stimA !== 2'd0 || busyA !== 1'b0 || doneA !== 1'b0 || passA !== 1'b0 || errA !== 3'd0) begin
            bad++;
            $display("[TB] FAIL midsweep_reset: got stim=%0d busy=%0b done=%0b pass=%0b err=%0d want all 0",
                     stimA, busyA, doneA, passA, errA);
        end
        expStimQ.delete();
        void'(resQ.pop_back());
        extraDone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (doneA) extraDone++;
        end
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (doneA) extraDone++;
        end
        total++;
        if (extraDone !== 0 || busyA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_no_done: got %0d done pulses busy=%0b want 0 0", extraDone, busyA);
        end
    endtask

    task automatic test_finish_start;
        int cyc;
        bit ok;
        modeOr = 1;
        applyStimulus(1, 1);
        @(negedge clk); startA = 1;
        @(negedge clk); startA = 0;
        waitDoneA(2, cyc, ok);
        checkOutputA(cyc, ok);
        modeOr = 0;
        applyStimulus(0, 1);
        startA = 1;
        @(negedge clk);
        total++;
        if (busyA !== 1'b0 || doneA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL finish_start_ignored: got busy=%0b done=%0b want 0 0", busyA, doneA);
        end
        @(negedge clk); startA = 0;
        total++;
        if (busyA !== 1'b1 || errA !== 3'd0 || passA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_restart_entry: got busy=%0b err=%0d pass=%0b want 1 0 0",
                     busyA, errA, passA);
        end
`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
        total++;
        if (ffVldA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL restart_ff_clear: got vld=%0b want 0", ffVldA);
        end
`endif
        waitDoneA(2, cyc, ok);
        checkOutputA(cyc, ok);
    endtask

    initial begin
        rst_n  = 0;
        startA = 0;
        startB = 0;
        startC = 0;
        modeOr = 0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1;
        test_and_pass;
        test_or_fail;
        test_settle3;
        test_all_wrong;
        test_back_to_back;
        test_finish_start;
        repeat (2) @(negedge clk);
        total++;
        if (expStimQ.size() !== 0 || resQ.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d stim and %0d results left want 0 0",
                     expStimQ.size(), resQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
